// File: rtl/fpaddsub_pkg.sv
// Shared widths, GRS field layout and operand unpack helpers for the FP add/sub datapath.
package fpaddsub_pkg;

   localparam int unsigned EXP_W_DEF  = 8;
   localparam int unsigned MAN_W_DEF  = 23;
   localparam int unsigned WORD_W_DEF = EXP_W_DEF + MAN_W_DEF + 1;
   localparam int unsigned EXT_W_DEF  = MAN_W_DEF + 4;

   // Guard/round/sticky bits sit below the mantissa in the extended field
   localparam int unsigned GRS_W = 3;
   localparam int unsigned G_OFS = 2;
   localparam int unsigned R_OFS = 1;
   localparam int unsigned S_OFS = 0;

   // Exponents are widened to this size when handed to the helpers
   localparam int unsigned UNPACK_W = 32;

   // Hidden bit: set for normal numbers, clear for zero/denormal
   function automatic logic hidden_bit(input logic [UNPACK_W-1:0] e);
      return (e != '0);
   endfunction

   // Effective exponent: denormals and zero behave as exponent 1
   function automatic logic [UNPACK_W-1:0] eff_exp(input logic [UNPACK_W-1:0] e);
      return (e == '0) ? UNPACK_W'(1) : e;
   endfunction

endpackage

// File: rtl/fpaddsub_shift_sticky.sv
// Combinational right shifter with saturation; every bit shifted out is folded into the sticky LSB.
module fpaddsub_shift_sticky
   import fpaddsub_pkg::*;
#(
   parameter int unsigned EXT_W = EXT_W_DEF,
   parameter int unsigned SH_W  = EXP_W_DEF
) (
   input  logic [EXT_W-1:0] din,
   input  logic [SH_W-1:0]  sh,
   output logic [EXT_W-1:0] dout_c
);

   logic [EXT_W-1:0] shifted;
   logic [EXT_W-1:0] mask;
   logic             lost;

   // Shift, collect lost bits, or collapse everything into sticky when the shift overruns the field
   always_comb begin
      shifted = '0;
      mask    = '0;
      lost    = 1'b0;
      dout_c  = '0;
      if (32'(sh) > (EXT_W - 1)) begin
         dout_c = EXT_W'(|din);
      end else begin
         shifted        = din >> sh;
         mask           = ~({EXT_W{1'b1}} << sh);
         lost           = |(din & mask);
         dout_c         = shifted;
         dout_c[S_OFS]  = shifted[S_OFS] | lost;
      end
   end

endmodule

// File: rtl/fpaddsub_align_pipe.sv
// Two-stage operand alignment for the FP adder: stage 1 unpacks/compares/swaps, stage 2 aligns the smaller mantissa.
module fpaddsub_align_pipe
   import fpaddsub_pkg::*;
#(
   parameter int unsigned EXP_W = EXP_W_DEF,
   parameter int unsigned MAN_W = MAN_W_DEF
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [EXP_W+MAN_W:0] A,
   input  logic [EXP_W+MAN_W:0] B,
   input  logic               Op,
   input  logic               InValid,
   output logic               InReady,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [EXP_W-1:0]   Es,
   output logic               MaxAB,
   output logic [MAN_W:0]     Mmax,
   output logic [MAN_W+3:0]   Mmin,
   output logic               Sa,
   output logic               Sb,
   output logic               ExcInf,
   output logic               ExcNaN
);

   localparam int unsigned WORD_W = EXP_W + MAN_W + 1;
   localparam int unsigned MAG_W  = EXP_W + MAN_W;
   localparam int unsigned EXT_W  = MAN_W + 1 + GRS_W;

   // Stage-1 combinational unpack/compare results
   logic [EXP_W-1:0] ea, eb, eea, eeb;
   logic [MAN_W-1:0] fa, fb;
   logic             ha, hb, b_big;
   logic [EXP_W-1:0] s1n_es, s1n_diff;
   logic [MAN_W:0]   s1n_mmax, s1n_mmin;
   logic             s1n_inf, s1n_nan;

   // Stage-1 registers
   logic             s1_v;
   logic [EXP_W-1:0] s1_es, s1_diff;
   logic [MAN_W:0]   s1_mmax, s1_mmin;
   logic             s1_maxab, s1_sa, s1_sb, s1_inf, s1_nan;

   logic             adv2;
   logic [EXT_W-1:0] s2n_mmin_c;

   // Stage 2 advances when empty or drained this cycle; stage 1 may load when stage 2 can take its contents
   assign adv2    = !OutValid | OutReady;
   assign InReady = !s1_v | adv2;

   // Unpack both operands, order by magnitude and form the exponent difference
   always_comb begin
      ea       = A[WORD_W-2 -: EXP_W];
      eb       = B[WORD_W-2 -: EXP_W];
      fa       = A[MAN_W-1:0];
      fb       = B[MAN_W-1:0];
      ha       = hidden_bit(UNPACK_W'(ea));
      hb       = hidden_bit(UNPACK_W'(eb));
      eea      = EXP_W'(eff_exp(UNPACK_W'(ea)));
      eeb      = EXP_W'(eff_exp(UNPACK_W'(eb)));
      b_big    = B[MAG_W-1:0] > A[MAG_W-1:0];
      s1n_es   = eea;
      s1n_mmax = {ha, fa};
      s1n_mmin = {hb, fb};
      s1n_diff = eea - eeb;
      if (b_big) begin
         s1n_es   = eeb;
         s1n_mmax = {hb, fb};
         s1n_mmin = {ha, fa};
         s1n_diff = eeb - eea;
      end
      s1n_inf = ((&ea) && (fa == '0)) || ((&eb) && (fb == '0));
      s1n_nan = ((&ea) && (fa != '0)) || ((&eb) && (fb != '0));
   end

   // Stage-1 register: capture the ordered operands on every accepted transfer
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_v     <= 1'b0;
         s1_es    <= '0;
         s1_diff  <= '0;
         s1_mmax  <= '0;
         s1_mmin  <= '0;
         s1_maxab <= 1'b0;
         s1_sa    <= 1'b0;
         s1_sb    <= 1'b0;
         s1_inf   <= 1'b0;
         s1_nan   <= 1'b0;
      end else if (InReady) begin
         s1_v <= InValid;
         if (InValid) begin
            s1_es    <= s1n_es;
            s1_diff  <= s1n_diff;
            s1_mmax  <= s1n_mmax;
            s1_mmin  <= s1n_mmin;
            s1_maxab <= b_big;
            s1_sa    <= A[WORD_W-1];
            s1_sb    <= B[WORD_W-1] ^ Op;
            s1_inf   <= s1n_inf;
            s1_nan   <= s1n_nan;
         end
      end
   end

   fpaddsub_shift_sticky #(
      .EXT_W (EXT_W),
      .SH_W  (EXP_W)
   ) u_shift (
      .din    ({s1_mmin, GRS_W'(0)}),
      .sh     (s1_diff),
      .dout_c (s2n_mmin_c)
   );

   // Stage-2 register: holds the aligned result stable under backpressure
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OutValid <= 1'b0;
         Es       <= '0;
         MaxAB    <= 1'b0;
         Mmax     <= '0;
         Mmin     <= '0;
         Sa       <= 1'b0;
         Sb       <= 1'b0;
         ExcInf   <= 1'b0;
         ExcNaN   <= 1'b0;
      end else if (adv2) begin
         OutValid <= s1_v;
         if (s1_v) begin
            Es     <= s1_es;
            MaxAB  <= s1_maxab;
            Mmax   <= s1_mmax;
            Mmin   <= s2n_mmin_c;
            Sa     <= s1_sa;
            Sb     <= s1_sb;
            ExcInf <= s1_inf;
            ExcNaN <= s1_nan;
         end
      end
   end

endmodule

// File: tb/tb_fpaddsub_align_pipe.sv
// Bench for the alignment pipe: table vectors through a scoreboard queue plus backpressure and reset sequences.
module tb_fpaddsub_align_pipe;

   typedef struct packed {
      logic [7:0]  es;
      logic        maxab;
      logic [23:0] mmax;
      logic [26:0] mmin;
      logic        sa;
      logic        sb;
      logic        inf;
      logic        nan;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      res_t        r;
   } vec_t;

   typedef struct {
      int   id;
      res_t r;
   } exp_t;

   localparam int unsigned NVEC = 12;

   logic        CLK;
   logic        RST_N;
   logic [31:0] A, B;
   logic        Op, InValid, InReady, OutValid, OutReady;
   logic [7:0]  Es;
   logic        MaxAB;
   logic [23:0] Mmax;
   logic [26:0] Mmin;
   logic        Sa, Sb, ExcInf, ExcNaN;

   res_t        got;
   vec_t        vec [NVEC];
   exp_t        q [$];
   exp_t        cur;
   int          checks = 0;
   int          passed = 0;
   int          stall_cycles = 0;
   logic        exp_in_ready;

   assign got = {Es, MaxAB, Mmax, Mmin, Sa, Sb, ExcInf, ExcNaN};

   fpaddsub_align_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .A        (A),
      .B        (B),
      .Op       (Op),
      .InValid  (InValid),
      .InReady  (InReady),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Es       (Es),
      .MaxAB    (MaxAB),
      .Mmax     (Mmax),
      .Mmin     (Mmin),
      .Sa       (Sa),
      .Sb       (Sb),
      .ExcInf   (ExcInf),
      .ExcNaN   (ExcNaN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] g, input logic [63:0] w);
      checks++;
      if (g === w) passed++;
      else $display("FAIL %s: got %h want %h", name, g, w);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                               input logic [7:0] es, input logic maxab, input logic [23:0] mmax,
                               input logic [26:0] mmin, input logic sa, input logic sb,
                               input logic inf, input logic nan);
      vec_t v;
      v.a  = a;
      v.b  = b;
      v.op = op;
      v.r  = {es, maxab, mmax, mmin, sa, sb, inf, nan};
      return v;
   endfunction

   // Scoreboard: track occupancy, check ready, compare outputs, push accepted operands
   always @(negedge CLK) begin
      if (!RST_N) begin
         q.delete();
      end else begin
         exp_in_ready = !((q.size() == 2) && !OutReady);
         chk("in_ready", 64'(InReady), 64'(exp_in_ready));
         if (!InReady) stall_cycles++;
         if (OutValid) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_output: got result %h want no output", got);
            end else begin
               chk($sformatf("result_id%0d", q[0].id), 64'(got), 64'(q[0].r));
               if (OutReady) void'(q.pop_front());
            end
         end
         if (InValid && InReady) q.push_back(cur);
      end
   end

   // Present one table vector and hold it until the stage accepts it
   task automatic send(input int i);
      bit done;
      A         = vec[i].a;
      B         = vec[i].b;
      Op        = vec[i].op;
      cur.id    = i;
      cur.r     = vec[i].r;
      InValid   = 1'b1;
      done      = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge CLK);
         if (InReady) done = 1'b1;
      end
      if (!done) chk("send_timeout", 64'(0), 64'(1));
      @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      for (int c = 0; c < 100 && q.size() != 0; c++) @(posedge CLK);
      chk("drain_empty", 64'(q.size()), 64'(0));
      #1;
   endtask

   initial begin
      int cnt;
      RST_N    = 1'b0;
      A        = '0;
      B        = '0;
      Op       = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b1;
      cur.id   = -1;
      cur.r    = '0;

      vec[0]  = mk(32'h3F800000, 32'h3FC00000, 1'b0, 8'h7F, 1'b1, 24'hC00000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[1]  = mk(32'h4B800000, 32'h3F800000, 1'b0, 8'h97, 1'b0, 24'h800000, 27'h0000004, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[2]  = mk(32'h53800000, 32'h3F800000, 1'b0, 8'hA7, 1'b0, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[3]  = mk(32'h00000001, 32'h00800000, 1'b0, 8'h01, 1'b1, 24'h800000, 27'h0000008, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[4]  = mk(32'h7F800000, 32'h7FC00000, 1'b0, 8'hFF, 1'b1, 24'hC00000, 27'h4000000, 1'b0, 1'b0, 1'b1, 1'b1);
      vec[5]  = mk(32'h40000000, 32'h40000000, 1'b1, 8'h80, 1'b0, 24'h800000, 27'h4000000, 1'b0, 1'b1, 1'b0, 1'b0);
      vec[6]  = mk(32'h41800000, 32'h3F800001, 1'b0, 8'h83, 1'b0, 24'h800000, 27'h0400001, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[7]  = mk(32'h3F800000, 32'hCC000000, 1'b1, 8'h98, 1'b1, 24'h800000, 27'h0000002, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[8]  = mk(32'h00000000, 32'h80000000, 1'b0, 8'h01, 1'b0, 24'h000000, 27'h0000000, 1'b0, 1'b1, 1'b0, 1'b0);
      vec[9]  = mk(32'h4D000000, 32'h3F800000, 1'b0, 8'h9A, 1'b0, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[10] = mk(32'h4D000000, 32'h00000000, 1'b0, 8'h9A, 1'b0, 24'h800000, 27'h0000000, 1'b0, 1'b0, 1'b0, 1'b0);
      vec[11] = mk(32'hBF800000, 32'h3F000000, 1'b0, 8'h7F, 1'b0, 24'h800000, 27'h2000000, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_outputs", 64'(got), 64'(0));
      chk("rst_outvalid", 64'(OutValid), 64'(0));
      @(posedge CLK);
      #2 RST_N = 1'b1;
      @(negedge CLK);
      chk("rst_inready", 64'(InReady), 64'(1));
      @(posedge CLK);
      #1;

      // Isolated vectors
      for (int i = 0; i < int'(NVEC); i++) begin
         send(i);
         InValid = 1'b0;
         drain();
      end

      // Back-to-back vectors at full throughput
      for (int i = 0; i < int'(NVEC); i++) send(i);
      InValid = 1'b0;
      drain();

      // Eight-deep stream with a backpressure window
      stall_cycles = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(i);
            InValid = 1'b0;
         end
         begin
            repeat (3) @(posedge CLK);
            #1 OutReady = 1'b0;
            repeat (4) @(posedge CLK);
            #1 OutReady = 1'b1;
         end
      join
      drain();
      chk("stream_stalled", 64'(stall_cycles > 0), 64'(1));

      // Reset with two operands in flight
      send(1);
      send(2);
      InValid = 1'b0;
      #1 RST_N = 1'b0;
      @(negedge CLK);
      chk("midrst_outputs", 64'(got), 64'(0));
      chk("midrst_outvalid", 64'(OutValid), 64'(0));
      @(posedge CLK);
      #2 RST_N = 1'b1;
      @(negedge CLK);
      chk("postrst_outvalid", 64'(OutValid), 64'(0));
      chk("postrst_inready", 64'(InReady), 64'(1));
      @(posedge CLK);
      #1;
      send(3);
      InValid = 1'b0;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         cnt++;
         if (OutValid) break;
      end
      chk("postrst_latency", 64'(cnt), 64'(2));
      @(posedge CLK);
      #1;
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
